motion_sequencer: RTL

- Upstream master of MotorsCtrl. Converts absolute pen-target commands (x, y, pen state) into a sequence of relative MotorsCtrl transactions (pulse_num_x, pulse_num_y, servo_pos, trigger/rdy).
- Tracks current plotter position and issues any pen change as a separate servo-only transaction before motion.
- Splits long moves into per-axis chunks bounded by MAX_CHUNK.

---
 rtl/motion_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/motion_sequencer.sv
// Converts absolute pen-target commands into relative MotorsCtrl transactions.
// Pen changes go out as servo-only transactions; long moves are split into clamped per-axis chunks.
module motion_sequencer #(
  parameter int POS_W     = 16,
  parameter int MAX_CHUNK = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    cmd_valid,
  output logic                    cmd_rdy,
  input  logic signed [POS_W-1:0] cmd_x,
  input  logic signed [POS_W-1:0] cmd_y,
  input  logic                    cmd_pen_down,
  output logic signed [POS_W-1:0] pulse_num_x,
  output logic signed [POS_W-1:0] pulse_num_y,
  output logic                    servo_pos,
  output logic                    trigger,
  input  logic                    motors_rdy,
  output logic signed [POS_W-1:0] pos_x,
  output logic signed [POS_W-1:0] pos_y,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT} state_t;

  localparam logic signed [POS_W:0] LIM_P = (POS_W+1)'(MAX_CHUNK);
  localparam logic signed [POS_W:0] LIM_N = -LIM_P;

  state_t                  state;
  logic signed [POS_W-1:0] tgt_x;
  logic signed [POS_W-1:0] tgt_y;
  logic                    tgt_pen;
  logic signed [POS_W:0]   dx;
  logic signed [POS_W:0]   dy;
  logic signed [POS_W-1:0] chunk_x;
  logic signed [POS_W-1:0] chunk_y;

  function automatic logic signed [POS_W-1:0] clamp(input logic signed [POS_W:0] d);
    if (d > LIM_P)      return LIM_P[POS_W-1:0];
    else if (d < LIM_N) return LIM_N[POS_W-1:0];
    else                return d[POS_W-1:0];
  endfunction

  // One extra bit so the difference of two extreme positions cannot wrap.
  assign dx      = {tgt_x[POS_W-1], tgt_x} - {pos_x[POS_W-1], pos_x};
  assign dy      = {tgt_y[POS_W-1], tgt_y} - {pos_y[POS_W-1], pos_y};
  assign chunk_x = clamp(dx);
  assign chunk_y = clamp(dy);

  assign cmd_rdy = (state == S_IDLE) && !reset;
  assign busy    = (state != S_IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tgt_x       <= '0;
      tgt_y       <= '0;
      tgt_pen     <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      servo_pos   <= 1'b0;
      pulse_num_x <= '0;
      pulse_num_y <= '0;
      trigger     <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            tgt_x   <= cmd_x;
            tgt_y   <= cmd_y;
            tgt_pen <= cmd_pen_down;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (tgt_pen != servo_pos) begin
            servo_pos   <= tgt_pen;
            pulse_num_x <= '0;
            pulse_num_y <= '0;
            trigger     <= 1'b1;
            state       <= S_REQ;
          end else if (tgt_x != pos_x || tgt_y != pos_y) begin
            pulse_num_x <= chunk_x;
            pulse_num_y <= chunk_y;
            trigger     <= 1'b1;
            state       <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        // Trigger stays up until MotorsCtrl shows it has taken the request.
        S_REQ: begin
          if (!motors_rdy) begin
            trigger <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (motors_rdy) begin
            pos_x <= pos_x + pulse_num_x;
            pos_y <= pos_y + pulse_num_y;
            state <= S_CHECK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
